// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage core: load-use bubbles, taken-branch squashes,
// and a mult/div freeze with start pulse and timeout release; saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int MD_TIMEOUT  = 40,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [4:0]             fd_readRegA,
    input  logic [4:0]             fd_readRegB,
    input  logic                   fd_usesA,
    input  logic                   fd_usesB,
    input  logic                   dx_MemRead,
    input  logic                   dx_RegWrite,
    input  logic [4:0]             dx_regDst,
    input  logic                   dx_multdiv,
    input  logic                   takeBranch,
    input  logic                   md_ready,
    input  logic                   md_exception,
    output logic                   stall_pc,
    output logic                   stall_fd,
    output logic                   stall_dx,
    output logic                   flush_fd,
    output logic                   flush_dx,
    output logic                   xm_bubble,
    output logic                   md_start,
    output logic                   md_timeout,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    typedef enum logic {
        IDLE    = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    localparam int WAIT_W = $clog2(MD_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MD_TIMEOUT - 1);

    state_t                   state_q, state_d;
    logic [WAIT_W-1:0]        wait_q, wait_d;
    logic [STALL_CNT_W-1:0]   cnt_q, cnt_d;
    logic                     lu;
    logic                     md_release;

    always_comb begin
        lu = dx_MemRead & dx_RegWrite & (dx_regDst != 5'd0) &
             ((fd_usesA & (fd_readRegA == dx_regDst)) |
              (fd_usesB & (fd_readRegB == dx_regDst)));
        md_release = md_ready | md_exception | (wait_q == WAIT_LAST);
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        stall_pc   = 1'b0;
        stall_fd   = 1'b0;
        stall_dx   = 1'b0;
        flush_fd   = 1'b0;
        flush_dx   = 1'b0;
        xm_bubble  = 1'b0;
        md_start   = 1'b0;
        md_timeout = 1'b0;

        case (state_q)
            IDLE: begin
                if (dx_multdiv) begin
                    md_start  = 1'b1;
                    stall_pc  = 1'b1;
                    stall_fd  = 1'b1;
                    stall_dx  = 1'b1;
                    xm_bubble = 1'b1;
                    state_d   = MD_BUSY;
                    wait_d    = '0;
                end else if (takeBranch) begin
                    // A load-use hit here belongs to a wrong-path instruction.
                    flush_fd = 1'b1;
                    flush_dx = 1'b1;
                end else if (lu) begin
                    stall_pc = 1'b1;
                    stall_fd = 1'b1;
                    flush_dx = 1'b1;
                end
            end
            MD_BUSY: begin
                if (md_release) begin
                    md_timeout = ~md_ready & ~md_exception;
                    state_d    = IDLE;
                end else begin
                    stall_pc  = 1'b1;
                    stall_fd  = 1'b1;
                    stall_dx  = 1'b1;
                    xm_bubble = 1'b1;
                    wait_d    = wait_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset cycle forces every control low regardless of inputs.
        if (reset) begin
            stall_pc   = 1'b0;
            stall_fd   = 1'b0;
            stall_dx   = 1'b0;
            flush_fd   = 1'b0;
            flush_dx   = 1'b0;
            xm_bubble  = 1'b0;
            md_start   = 1'b0;
            md_timeout = 1'b0;
        end

        cnt_d = cnt_q;
        if (stall_pc && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_cycles = reset ? '0 : cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: load-use, branch squash, mult/div ready,
// timeout, exception release, back-to-back start and reset mid-operation.
module tb_pipe_hazard_ctrl;

    logic        clock;
    logic        reset;
    logic [4:0]  fd_readRegA, fd_readRegB;
    logic        fd_usesA, fd_usesB;
    logic        dx_MemRead, dx_RegWrite;
    logic [4:0]  dx_regDst;
    logic        dx_multdiv, takeBranch, md_ready, md_exception;
    logic        stall_pc, stall_fd, stall_dx, flush_fd, flush_dx;
    logic        xm_bubble, md_start, md_timeout;
    logic [15:0] stall_cycles;
    logic [7:0]  outs;

    int total = 0;
    int bad   = 0;

    // Bit order: stall_pc stall_fd stall_dx flush_fd flush_dx xm_bubble md_start md_timeout
    localparam logic [7:0] O_NONE  = 8'b0000_0000;
    localparam logic [7:0] O_LU    = 8'b1100_1000;
    localparam logic [7:0] O_BR    = 8'b0001_1000;
    localparam logic [7:0] O_START = 8'b1110_0110;
    localparam logic [7:0] O_BUSY  = 8'b1110_0100;
    localparam logic [7:0] O_TMO   = 8'b0000_0001;

    pipe_hazard_ctrl #(.MD_TIMEOUT(40), .STALL_CNT_W(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .fd_readRegA  (fd_readRegA),
        .fd_readRegB  (fd_readRegB),
        .fd_usesA     (fd_usesA),
        .fd_usesB     (fd_usesB),
        .dx_MemRead   (dx_MemRead),
        .dx_RegWrite  (dx_RegWrite),
        .dx_regDst    (dx_regDst),
        .dx_multdiv   (dx_multdiv),
        .takeBranch   (takeBranch),
        .md_ready     (md_ready),
        .md_exception (md_exception),
        .stall_pc     (stall_pc),
        .stall_fd     (stall_fd),
        .stall_dx     (stall_dx),
        .flush_fd     (flush_fd),
        .flush_dx     (flush_dx),
        .xm_bubble    (xm_bubble),
        .md_start     (md_start),
        .md_timeout   (md_timeout),
        .stall_cycles (stall_cycles)
    );

    assign outs = {stall_pc, stall_fd, stall_dx, flush_fd, flush_dx, xm_bubble, md_start, md_timeout};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        fd_readRegA  = 5'd0;
        fd_readRegB  = 5'd0;
        fd_usesA     = 1'b0;
        fd_usesB     = 1'b0;
        dx_MemRead   = 1'b0;
        dx_RegWrite  = 1'b0;
        dx_regDst    = 5'd0;
        dx_multdiv   = 1'b0;
        takeBranch   = 1'b0;
        md_ready     = 1'b0;
        md_exception = 1'b0;
    endtask

    // Advance one edge, then leave time for new inputs before sampling.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_load_r3();
        dx_MemRead  = 1'b1;
        dx_RegWrite = 1'b1;
        dx_regDst   = 5'd3;
    endtask

    initial begin
        clr();
        reset = 1'b1;
        // Hazard-producing inputs during reset must not leak to outputs.
        dx_multdiv = 1'b1;
        takeBranch = 1'b1;
        set_load_r3();
        fd_readRegA = 5'd3;
        fd_usesA = 1'b1;
        #3;
        chk("reset_outs", 32'(outs), 32'(O_NONE));
        chk("reset_cnt", 32'(stall_cycles), 32'd0);

        step();
        reset = 1'b0;
        clr();
        #2;
        chk("idle_outs", 32'(outs), 32'(O_NONE));
        chk("idle_cnt", 32'(stall_cycles), 32'd0);

        // Load-use via source A
        step();
        set_load_r3();
        fd_readRegA = 5'd3;
        fd_usesA = 1'b1;
        #2;
        chk("lu_a", 32'(outs), 32'(O_LU));

        step();
        clr();
        #2;
        chk("lu_a_one_bubble", 32'(outs), 32'(O_NONE));
        chk("lu_a_cnt", 32'(stall_cycles), 32'd1);

        // Load-use via source B only
        set_load_r3();
        fd_readRegA = 5'd3;
        fd_readRegB = 5'd3;
        fd_usesB = 1'b1;
        #1;
        chk("lu_b", 32'(outs), 32'(O_LU));

        // Register zero never stalls
        step();
        clr();
        dx_MemRead = 1'b1;
        dx_RegWrite = 1'b1;
        fd_usesA = 1'b1;
        #2;
        chk("lu_r0", 32'(outs), 32'(O_NONE));
        chk("lu_b_cnt", 32'(stall_cycles), 32'd2);

        // Source not used
        set_load_r3();
        fd_usesA = 1'b0;
        fd_readRegA = 5'd3;
        #1;
        chk("lu_unused_src", 32'(outs), 32'(O_NONE));

        // Producer not a load
        fd_usesA = 1'b1;
        dx_MemRead = 1'b0;
        #1;
        chk("lu_not_load", 32'(outs), 32'(O_NONE));

        // Different destination
        dx_MemRead = 1'b1;
        dx_regDst = 5'd4;
        #1;
        chk("lu_other_dst", 32'(outs), 32'(O_NONE));

        // Taken branch wins over a load-use
        dx_regDst = 5'd3;
        takeBranch = 1'b1;
        #1;
        chk("branch_over_lu", 32'(outs), 32'(O_BR));

        // Mult/div with ready on the 5th busy cycle; ready in the start cycle is ignored
        step();
        clr();
        dx_multdiv = 1'b1;
        md_ready = 1'b1;
        #2;
        chk("md_start", 32'(outs), 32'(O_START));
        chk("md_pre_cnt", 32'(stall_cycles), 32'd2);
        md_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            #2;
            chk($sformatf("md_busy%0d", i), 32'(outs), 32'(O_BUSY));
        end
        step();
        md_ready = 1'b1;
        #2;
        chk("md_release", 32'(outs), 32'(O_NONE));
        step();
        clr();
        #2;
        chk("md_back_idle", 32'(outs), 32'(O_NONE));
        chk("md_cnt", 32'(stall_cycles), 32'd7);

        // Timeout: ready never comes
        step();
        dx_multdiv = 1'b1;
        #2;
        chk("tmo_start", 32'(outs), 32'(O_START));
        for (int i = 1; i <= 39; i++) begin
            step();
            #2;
            chk($sformatf("tmo_busy%0d", i), 32'(outs), 32'(O_BUSY));
        end
        step();
        #2;
        chk("tmo_release", 32'(outs), 32'(O_TMO));
        chk("tmo_cnt", 32'(stall_cycles), 32'd47);

        // A new mult/div right after the release starts normally
        step();
        #2;
        chk("restart", 32'(outs), 32'(O_START));
        step();
        md_exception = 1'b1;
        #2;
        chk("exc_release", 32'(outs), 32'(O_NONE));
        step();
        clr();
        #2;
        chk("exc_idle", 32'(outs), 32'(O_NONE));
        chk("exc_cnt", 32'(stall_cycles), 32'd48);

        // Reset on the 3rd busy cycle
        step();
        dx_multdiv = 1'b1;
        #2;
        chk("rst_op_start", 32'(outs), 32'(O_START));
        step();
        step();
        #2;
        chk("rst_op_busy2", 32'(outs), 32'(O_BUSY));
        step();
        reset = 1'b1;
        #2;
        chk("rst_op_outs", 32'(outs), 32'(O_NONE));
        step();
        reset = 1'b0;
        clr();
        #2;
        chk("rst_op_idle", 32'(outs), 32'(O_NONE));
        chk("rst_op_cnt", 32'(stall_cycles), 32'd0);

        // State really is IDLE: a branch is honoured again
        takeBranch = 1'b1;
        #1;
        chk("rst_op_branch", 32'(outs), 32'(O_BR));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
